// File: rtl/address_decoder_ws.sv
// Registered CPU address decoder: maps the address onto base/limit windows,
// stalls the CPU per-region through rdy_o, and latches the first unmapped access.
module address_decoder_ws #(
   parameter int ADDR_W      = 16,
   parameter int NUM_REGIONS = 8,
   parameter int WS_W        = 4,
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
      {16'hffff, 16'hfffa, 16'h8000, 16'h7000, 16'h5000, 16'h4000, 16'h4000, 16'h0000},
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT =
      {16'h0000, 16'hffff, 16'hfff9, 16'h7003, 16'h6fff, 16'h4fff, 16'h41ff, 16'h3fff},
   parameter logic [NUM_REGIONS*WS_W-1:0] REGION_WAIT =
      {4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd1, 4'd1, 4'd0},
   localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [ADDR_W-1:0]      cpu_address_i,
   input  logic                   cpu_valid_i,
   input  logic                   clr_unmapped_i,
   output logic [NUM_REGIONS-1:0] SELECT_o,
   output logic [IDX_W-1:0]       region_o,
   output logic                   rdy_o,
   output logic                   unmapped_o,
   output logic [ADDR_W-1:0]      unmapped_address_o
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   logic [NUM_REGIONS-1:0] hit;

   // A window with base above limit never hits, which is how regions are disabled.
   generate
      for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_match
         logic [ADDR_W-1:0] base_c;
         logic [ADDR_W-1:0] limit_c;
         assign base_c  = REGION_BASE[gi*ADDR_W +: ADDR_W];
         assign limit_c = REGION_LIMIT[gi*ADDR_W +: ADDR_W];
         assign hit[gi] = (base_c <= limit_c) &&
                          (cpu_address_i >= base_c) &&
                          (cpu_address_i <= limit_c);
      end
   endgenerate

   logic             hit_any;
   logic [IDX_W-1:0] hit_idx;
   logic [WS_W-1:0]  hit_wait;

   // Scan high-to-low so the lowest hitting index is the one left standing.
   always_comb begin
      hit_any  = 1'b0;
      hit_idx  = '0;
      hit_wait = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (hit[i]) begin
            hit_any  = 1'b1;
            hit_idx  = IDX_W'(i);
            hit_wait = REGION_WAIT[i*WS_W +: WS_W];
         end
      end
   end

   logic [0:0]             state_q, state_d;
   logic [WS_W-1:0]        cnt_q, cnt_d;
   logic [NUM_REGIONS-1:0] sel_q, sel_d;
   logic [IDX_W-1:0]       region_q, region_d;
   logic                   rdy_q, rdy_d;
   logic                   unmapped_q, unmapped_d;
   logic [ADDR_W-1:0]      uaddr_q, uaddr_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sel_d      = sel_q;
      region_d   = region_q;
      rdy_d      = rdy_q;
      unmapped_d = unmapped_q;
      uaddr_d    = uaddr_q;

      if (clr_unmapped_i) begin
         unmapped_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            sel_d = '0;
            if (cpu_valid_i) begin
               if (hit_any) begin
                  sel_d[hit_idx] = 1'b1;
                  region_d       = hit_idx;
                  if (hit_wait != '0) begin
                     rdy_d   = 1'b0;
                     cnt_d   = hit_wait - 1'b1;
                     state_d = ST_WAIT;
                  end
               end else if (!unmapped_q || clr_unmapped_i) begin
                  // A fresh unmapped access beats a simultaneous clear.
                  unmapped_d = 1'b1;
                  uaddr_d    = cpu_address_i;
               end
            end
         end
         default: begin
            if (cnt_q == '0) begin
               rdy_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         sel_q      <= '0;
         region_q   <= '0;
         rdy_q      <= 1'b1;
         unmapped_q <= 1'b0;
         uaddr_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         region_q   <= region_d;
         rdy_q      <= rdy_d;
         unmapped_q <= unmapped_d;
         uaddr_q    <= uaddr_d;
      end
   end

   assign SELECT_o           = sel_q;
   assign region_o           = region_q;
   assign rdy_o              = rdy_q;
   assign unmapped_o         = unmapped_q;
   assign unmapped_address_o = uaddr_q;

endmodule
